wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master Wishbone arbiter with a bus watchdog, placed directly upstream of `wb_switch`; its single master-side output drives the switch's `m_*` interface. It grants bus ownership round-robin, holds the grant for the whole of the owner's `cyc` cycle, and routes slave data and ack back to the owner. A watchdog completes any strobe that no slave acknowledges, so an unmapped or dead slave cannot hang a master.

## Interface
Parameters:
- `TIMEOUT`, default 255: consecutive unacknowledged strobe cycles before the watchdog completes the access; 0 disables the watchdog.
- `ERR_DATA`, default 32'hFFFFFFFF: read data returned on a watchdog completion.

Ports (one clock; reset is asynchronous and active-high):
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `m0_dat_i` in 32, `m0_adr_i` in 32, `m0_sel_i` in 4, `m0_we_i` in 1, `m0_cyc_i` in 1, `m0_stb_i` in 1: master 0 request.
- `m0_dat_o` out 32, `m0_ack_o` out 1: master 0 response.
- `m1_*`: identical set for master 1.
- `s_dat_o` out 32, `s_adr_o` out 32, `s_sel_o` out 4, `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1: to switch `m_*` inputs.
- `s_dat_i` in 32, `s_ack_i` in 1: from switch `m_dat_o` / `m_ack_o`.
- `timeout_o` out 1: one-cycle pulse on each watchdog completion.

## Operation
- States: IDLE, GNT0, GNT1. Registered. `last` flag records the most recently granted master.
- IDLE: if exactly one `mX_cyc_i` is high, go to GNTX. If both are high, grant the master that is not `last`. Update `last` on every grant.
- GNTX while `mX_cyc_i` = 1: stay. No preemption.
- GNTX when `mX_cyc_i` = 0: if the other master's cyc is high, go directly to GNTother (no IDLE bubble); else go to IDLE.
- Output mux (combinational from state):
  - GNTX: `s_*` = `mX_*`.
  - IDLE: `s_cyc_o` = `s_stb_o` = 0; the remaining `s_*` carry m0 values.
- Response routing:
  - `mX_ack_o` = (state == GNTX) & `mX_stb_i` & (`s_ack_i` | wd_fire).
  - `mX_dat_o` = wd_fire ? ERR_DATA : `s_dat_i` when granted, else 0.
  - The non-granted master never sees ack.
- Watchdog:
  - `cnt` is width $clog2(TIMEOUT+1). It clears when `s_stb_o` = 0 or `s_ack_i` = 1; otherwise it increments.
  - wd_fire = (TIMEOUT != 0) & `s_stb_o` & ~`s_ack_i` & (`cnt` == TIMEOUT). On fire, `cnt` clears.
  - `timeout_o` = wd_fire, combinational, single cycle.
- A real `s_ack_i` in the fire cycle wins: wd_fire is 0 and the slave data is returned.

## Timing
- Reset values: state = IDLE, `last` = 1 (m0 wins first contention), `cnt` = 0. All outputs are low except `s_adr_o`/`s_dat_o`/`s_sel_o`/`s_we_o`, which follow `m0_*`.
- Grant latency: cyc rising, sampled at edge E, gives `s_cyc_o` high in the cycle after E.
- Handover: the owner's cyc is low at edge E; the other master drives the bus in the cycle after E.
- Ack and data pass through combinationally with zero added latency. Back-to-back strobes are supported within one cyc.
- Watchdog completion: the strobe has been high with no ack for TIMEOUT+1 cycles; the ack appears in cycle TIMEOUT+1 of the strobe.
- Reset asserted mid-transfer: the bus is dropped immediately (`s_cyc_o` = 0 asynchronously). No ack is issued.

## Structure
- Package `wb_pkg`: state encoding (IDLE/GNT0/GNT1), the `ERR_DATA` default, and the bus-width constants (32 adr, 32 dat, 4 sel).
- Sub-module `wb_watchdog`: holds the counter and fire logic, with inputs stb, ack and parameter TIMEOUT.

## Test plan
- Reset, then m0 issues a single read at 32'h0000_1000, slave acks with 32'hDEAD_BEEF one cycle later -> `s_cyc_o` rises one cycle after `m0_cyc_i`; `m0_dat_o` = DEADBEEF with ack; `m1_ack_o` stays 0.
- m0 and m1 raise cyc in the same cycle twice in succession -> first grant to m0, second to m1 (round-robin); `last` alternates.
- m0 holds cyc for 4 acked strobes while m1 requests -> m1 is not granted until m0 drops cyc; m1 then owns the bus the next cycle with no IDLE cycle.
- TIMEOUT = 8, m1 strobes address 32'hFFFF_0000 with no slave ack -> ack after 9 cycles, `m1_dat_o` = FFFFFFFF, `timeout_o` pulses once, `cnt` returns to 0.
- TIMEOUT = 8, `s_ack_i` arrives exactly in the fire cycle -> slave data returned, `timeout_o` = 0. Separately, TIMEOUT = 0 with no ack -> never completes.
- Assert `wb_rst_i` mid-burst of m1 -> `s_cyc_o`/`s_stb_o` drop immediately; after release, m0 wins the next contention.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, grant-state encoding and arbitration helper
package wb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [DAT_W-1:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  // Choose the next owner from the raw requests; contention goes to whoever
  // was not granted most recently.
  function automatic arb_state_t next_grant(input logic c0, input logic c1,
                                            input logic last_m1);
    arb_state_t g;
    if (c0 && c1)
      g = last_m1 ? ST_GNT0 : ST_GNT1;
    else if (c0)
      g = ST_GNT0;
    else if (c1)
      g = ST_GNT1;
    else
      g = ST_IDLE;
    return g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - completes strobes left unacknowledged for TIMEOUT+1 cycles
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic fire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  // A genuine slave ack in the terminal cycle suppresses the fire.
  assign fire = (TIMEOUT != 0) && stb && !ack && (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!stb || ack || fire)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin Wishbone arbiter with bus watchdog
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int                TIMEOUT  = 255,
  parameter logic [DAT_W-1:0]  ERR_DATA = ERR_DATA_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,

  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,

  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,

  output logic [DAT_W-1:0] s_dat_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,

  output logic             timeout_o
);

  arb_state_t state;
  arb_state_t nxt;
  logic       last;
  logic       holding;
  logic       gnt0;
  logic       gnt1;
  logic       wd_fire;
  logic [DAT_W-1:0] resp_dat;

  always_comb begin
    holding = ((state == ST_GNT0) && m0_cyc_i) || ((state == ST_GNT1) && m1_cyc_i);
    nxt     = next_grant(m0_cyc_i, m1_cyc_i, last);
  end

  // When the owner releases, the other requester is granted directly so a
  // handover never costs an idle cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else if (!holding) begin
      state <= nxt;
      if (nxt != ST_IDLE)
        last <= (nxt == ST_GNT1);
    end
  end

  assign gnt0 = (state == ST_GNT0);
  assign gnt1 = (state == ST_GNT1);

  always_comb begin
    s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
    s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
    s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
    s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
    s_cyc_o = (gnt0 && m0_cyc_i) || (gnt1 && m1_cyc_i);
    s_stb_o = (gnt0 && m0_stb_i) || (gnt1 && m1_stb_i);
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .stb  (s_stb_o),
    .ack  (s_ack_i),
    .fire (wd_fire)
  );

  assign resp_dat  = wd_fire ? ERR_DATA : s_dat_i;
  assign m0_ack_o  = gnt0 && m0_stb_i && (s_ack_i || wd_fire);
  assign m1_ack_o  = gnt1 && m1_stb_i && (s_ack_i || wd_fire);
  assign m0_dat_o  = gnt0 ? resp_dat : '0;
  assign m1_dat_o  = gnt1 ? resp_dat : '0;
  assign timeout_o = wd_fire;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scenario and randomized checks of wb_arbiter against a behavioural model
module tb_wb_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic [31:0] s_dat_in;
  logic        s_ack;

  logic [31:0] mdat [2];
  logic [1:0]  mack;
  logic [31:0] s_dat_o, s_adr_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, timeout;

  logic [31:0] nt_mdat [2];
  logic [1:0]  nt_mack;
  logic [31:0] nt_s_dat, nt_s_adr;
  logic [3:0]  nt_s_sel;
  logic        nt_s_we, nt_s_cyc, nt_s_stb, nt_timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, who won last, how long the strobe has waited.
  int          owner;
  bit          last_m1;
  int          wait_cnt;
  logic        e_cyc, e_stb, e_we, e_fire;
  logic [1:0]  e_ack;
  logic [31:0] e_adr, e_sdat;
  logic [3:0]  e_sel;
  logic [31:0] e_dat [2];

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .m0_dat_i (wdat[0]), .m0_adr_i (adr[0]), .m0_sel_i (sel[0]), .m0_we_i (we[0]),
    .m0_cyc_i (cyc[0]), .m0_stb_i (stb[0]), .m0_dat_o (mdat[0]), .m0_ack_o (mack[0]),
    .m1_dat_i (wdat[1]), .m1_adr_i (adr[1]), .m1_sel_i (sel[1]), .m1_we_i (we[1]),
    .m1_cyc_i (cyc[1]), .m1_stb_i (stb[1]), .m1_dat_o (mdat[1]), .m1_ack_o (mack[1]),
    .s_dat_o (s_dat_o), .s_adr_o (s_adr_o), .s_sel_o (s_sel_o), .s_we_o (s_we_o),
    .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_dat_i (s_dat_in), .s_ack_i (s_ack),
    .timeout_o (timeout)
  );

  wb_arbiter #(.TIMEOUT(0)) dut_nt (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .m0_dat_i (wdat[0]), .m0_adr_i (adr[0]), .m0_sel_i (sel[0]), .m0_we_i (we[0]),
    .m0_cyc_i (cyc[0]), .m0_stb_i (stb[0]), .m0_dat_o (nt_mdat[0]), .m0_ack_o (nt_mack[0]),
    .m1_dat_i (wdat[1]), .m1_adr_i (adr[1]), .m1_sel_i (sel[1]), .m1_we_i (we[1]),
    .m1_cyc_i (cyc[1]), .m1_stb_i (stb[1]), .m1_dat_o (nt_mdat[1]), .m1_ack_o (nt_mack[1]),
    .s_dat_o (nt_s_dat), .s_adr_o (nt_s_adr), .s_sel_o (nt_s_sel), .s_we_o (nt_s_we),
    .s_cyc_o (nt_s_cyc), .s_stb_o (nt_s_stb), .s_dat_i (s_dat_in), .s_ack_i (s_ack),
    .timeout_o (nt_timeout)
  );

  task automatic model_reset();
    owner    = -1;
    last_m1  = 1'b1;
    wait_cnt = 0;
  endtask

  task automatic model_eval();
    e_cyc  = (owner >= 0) ? cyc[owner] : 1'b0;
    e_stb  = (owner >= 0) ? stb[owner] : 1'b0;
    e_adr  = (owner == 1) ? adr[1]  : adr[0];
    e_sdat = (owner == 1) ? wdat[1] : wdat[0];
    e_sel  = (owner == 1) ? sel[1]  : sel[0];
    e_we   = (owner == 1) ? we[1]   : we[0];
    e_fire = (TO != 0) && e_stb && !s_ack && (wait_cnt == TO);
    for (int m = 0; m < 2; m++) begin
      e_ack[m] = (owner == m) && stb[m] && (s_ack || e_fire);
      e_dat[m] = (owner == m) ? (e_fire ? 32'hFFFF_FFFF : s_dat_in) : 32'h0;
    end
  endtask

  task automatic model_advance();
    int n;
    if (rst) begin
      model_reset();
    end else begin
      wait_cnt = (!e_stb || s_ack || e_fire) ? 0 : wait_cnt + 1;
      if (!(owner >= 0 && cyc[owner] == 1'b1)) begin
        if (cyc[0] && cyc[1]) n = last_m1 ? 0 : 1;
        else if (cyc[0])      n = 0;
        else if (cyc[1])      n = 1;
        else                  n = -1;
        if (n >= 0) last_m1 = (n == 1);
        owner = n;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cyc = 2'b00; stb = 2'b00; s_ack = 1'b0; s_dat_in = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    we = 2'b00;
    for (int m = 0; m < 2; m++) begin adr[m] = 32'h0; wdat[m] = 32'h0; sel[m] = 4'h0; end
    rst = 1'b1;
    cyc = 2'b11; stb = 2'b11; s_ack = 1'b1;
    adr[0] = 32'hA5A5_0004; wdat[0] = 32'h1234_5678; sel[0] = 4'hC; we[0] = 1'b1;
    adr[1] = 32'h5A5A_0008; wdat[1] = 32'h8765_4321; sel[1] = 4'h3;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, mack, timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {s_cyc_o, s_stb_o, mack, timeout});
    end
    checks++;
    if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== {32'hA5A5_0004, 32'h1234_5678, 4'hC, 1'b1}) begin
      errors++; $display("FAIL reset_mux got=%h/%h/%h/%b", s_adr_o, s_dat_o, s_sel_o, s_we_o);
    end
    checks++;
    if ({mdat[0], mdat[1]} !== 64'h0) begin
      errors++; $display("FAIL reset_mdat got=%h/%h exp=0", mdat[0], mdat[1]);
    end
    we[0] = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    idle_inputs();
    adr[0] = 32'h0000_1000; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
    settle();
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL sr_early_grant got=%b exp=0", s_cyc_o); end
    tick();
    settle();
    checks++;
    if ({s_cyc_o, s_stb_o, s_adr_o} !== {2'b11, 32'h0000_1000}) begin
      errors++; $display("FAIL sr_grant got=%b%b %h exp=11 00001000", s_cyc_o, s_stb_o, s_adr_o);
    end
    checks++;
    if (mack[0] !== 1'b0) begin errors++; $display("FAIL sr_early_ack got=%b exp=0", mack[0]); end
    tick();
    s_ack = 1'b1; s_dat_in = 32'hDEAD_BEEF;
    settle();
    checks++;
    if ({mack[0], mdat[0]} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL sr_data got=%b %h exp=1 deadbeef", mack[0], mdat[0]);
    end
    checks++;
    if (mack[1] !== 1'b0) begin errors++; $display("FAIL sr_m1_ack got=%b exp=0", mack[1]); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] want;
    do_reset();
    adr[0] = 32'h0000_0100; adr[1] = 32'h0000_0200;
    for (int r = 0; r < 3; r++) begin
      cyc = 2'b11; stb = 2'b00;
      tick();
      settle();
      want = (r % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      checks++;
      if ({s_cyc_o, s_adr_o} !== {1'b1, want}) begin
        errors++; $display("FAIL rr_round%0d got=%b %h exp=1 %h", r, s_cyc_o, s_adr_o, want);
      end
      cyc = 2'b00;
      tick();
    end
  endtask

  task automatic test_no_preempt();
    idle_inputs();
    adr[0] = 32'h0000_3000; adr[1] = 32'h0000_4000;
    cyc[0] = 1'b1;
    tick();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stb[0] = 1'b1; s_ack = 1'b1; s_dat_in = 32'hC0DE_0000 + i;
      settle();
      checks++;
      if ({s_adr_o, mack, mdat[0]} !== {32'h0000_3000, 2'b01, 32'hC0DE_0000 + i}) begin
        errors++; $display("FAIL np_burst%0d got=%h %b %h", i, s_adr_o, mack, mdat[0]);
      end
      tick();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
    settle();
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL np_release got=%b exp=0", s_cyc_o); end
    tick();
    settle();
    checks++;
    if ({s_cyc_o, s_stb_o, s_adr_o} !== {2'b11, 32'h0000_4000}) begin
      errors++; $display("FAIL np_handover got=%b%b %h exp=11 00004000", s_cyc_o, s_stb_o, s_adr_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    logic hit;
    idle_inputs();
    adr[1] = 32'hFFFF_0000; cyc[1] = 1'b1; stb[1] = 1'b1; s_dat_in = 32'h1111_2222;
    tick();
    for (int k = 1; k <= 2 * (TO + 1); k++) begin
      settle();
      hit = (k == TO + 1) || (k == 2 * (TO + 1));
      checks++;
      if ({mack[1], timeout} !== {hit, hit}) begin
        errors++; $display("FAIL to_cycle%0d got=%b%b exp=%b%b", k, mack[1], timeout, hit, hit);
      end
      if (hit) begin
        checks++;
        if (mdat[1] !== 32'hFFFF_FFFF) begin
          errors++; $display("FAIL to_data%0d got=%h exp=ffffffff", k, mdat[1]);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_ack_in_fire();
    idle_inputs();
    adr[0] = 32'h0000_5000; cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    for (int k = 1; k <= 2 * (TO + 1); k++) begin
      s_ack = (k == TO + 1);
      s_dat_in = (k == TO + 1) ? 32'h1234_5678 : 32'h0;
      settle();
      checks++;
      if ({mack[0], timeout} !== {(k == TO + 1) || (k == 2 * (TO + 1)), k == 2 * (TO + 1)}) begin
        errors++; $display("FAIL aif_cycle%0d got=%b%b", k, mack[0], timeout);
      end
      if (k == TO + 1) begin
        checks++;
        if (mdat[0] !== 32'h1234_5678) begin
          errors++; $display("FAIL aif_data got=%h exp=12345678", mdat[0]);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout_zero();
    idle_inputs();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      settle();
      checks++;
      if ({nt_s_stb, nt_mack[0], nt_timeout} !== 3'b100) begin
        errors++; $display("FAIL tz_cycle%0d got=%b exp=100", k, {nt_s_stb, nt_mack[0], nt_timeout});
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (cyc[m]) begin
          if ($urandom_range(0, 9) == 0) begin cyc[m] = 1'b0; stb[m] = 1'b0; end
          else stb[m] = ($urandom_range(0, 3) != 0);
        end else if ($urandom_range(0, 3) == 0) begin
          cyc[m] = 1'b1; stb[m] = $urandom_range(0, 1);
        end
        adr[m] = $urandom; wdat[m] = $urandom; sel[m] = 4'($urandom); we[m] = $urandom_range(0, 1);
      end
      s_ack = ($urandom_range(0, 5) == 0);
      s_dat_in = $urandom;
      settle();
      checks++;
      if ({s_cyc_o, s_stb_o, mack, timeout} !== {e_cyc, e_stb, e_ack, e_fire}) begin
        errors++; $display("FAIL rnd_ctrl%0d got=%b exp=%b", n,
                           {s_cyc_o, s_stb_o, mack, timeout}, {e_cyc, e_stb, e_ack, e_fire});
      end
      checks++;
      if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== {e_adr, e_sdat, e_sel, e_we}) begin
        errors++; $display("FAIL rnd_bus%0d got=%h %h %h %b exp=%h %h %h %b", n,
                           s_adr_o, s_dat_o, s_sel_o, s_we_o, e_adr, e_sdat, e_sel, e_we);
      end
      checks++;
      if ({mdat[0], mdat[1]} !== {e_dat[0], e_dat[1]}) begin
        errors++; $display("FAIL rnd_mdat%0d got=%h %h exp=%h %h", n, mdat[0], mdat[1], e_dat[0], e_dat[1]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    adr[0] = 32'h0000_A000; adr[1] = 32'h0000_ABC0;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      s_ack = 1'b1; s_dat_in = 32'hBEEF_0000 + i;
      settle();
      checks++;
      if ({s_adr_o, mack[1]} !== {32'h0000_ABC0, 1'b1}) begin
        errors++; $display("FAIL rm_burst%0d got=%h %b", i, s_adr_o, mack[1]);
      end
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, mack} !== 4'b0) begin
      errors++; $display("FAIL rm_drop got=%b exp=0000", {s_cyc_o, s_stb_o, mack});
    end
    model_reset();
    cyc = 2'b11; stb = 2'b00; s_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    settle();
    checks++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h0000_A000}) begin
      errors++; $display("FAIL rm_first_win got=%b %h exp=1 0000a000", s_cyc_o, s_adr_o);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_ack_in_fire();
    test_timeout_zero();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
